// File: rtl/uart_char_receiver.sv
// uart_char_receiver: 8N1 UART receiver for the SmartHouse command path.
// Synchronizes rx, checks the start bit at mid-bit, samples each data bit
// and the stop bit at mid-bit, and presents each good byte with a
// one-cycle char_valid pulse. A low stop bit pulses framing_error.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit between
// the data and stop bits and drives parity_error. When it is undefined the
// frame is plain 8N1 and parity_error is tied low.
module uart_char_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] char,
  output logic       char_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q;
  logic          sync1_q, sync2_q;
  logic          rxs;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sr_q;
  logic [7:0]    char_q;
  logic          char_valid_q;
  logic          framing_error_q;
  logic          parity_error_q;
  logic          busy_q;
`ifdef UART_PARITY_EN
  logic          par_q;
`endif

  assign rxs = sync2_q;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM with bit timing, shifting and registered result pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      sr_q            <= '0;
      char_q          <= '0;
      char_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
      busy_q          <= 1'b0;
`ifdef UART_PARITY_EN
      par_q           <= 1'b0;
`endif
    end else begin
      char_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            cnt_q   <= '0;
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rxs) begin
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              // Start bit vanished before mid-bit: a glitch, not a frame.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            sr_q  <= {rxs, sr_q[7:1]};
            idx_q <= idx_q + 1'b1;
            if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            par_q   <= rxs;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!rxs) begin
              framing_error_q <= 1'b1;
`ifdef UART_PARITY_EN
            end else if (^{sr_q, par_q}) begin
              parity_error_q <= 1'b1;
`endif
            end else begin
              char_q       <= sr_q;
              char_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign char          = char_q;
  assign char_valid    = char_valid_q;
  assign framing_error = framing_error_q;
  assign parity_error  = parity_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_char_receiver.sv
// Testbench for uart_char_receiver with CLKS_PER_BIT = 16. Frames are
// driven bit by bit; a frame-level model predicts the kind, data and cycle
// of every result pulse, and a negedge monitor records what the DUT emits.
module tb_uart_char_receiver;

  localparam int N = 16;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // Result pulse cycle relative to the first edge that sees rx low.
  localparam int LAT = 2 + N / 2 + 9 * N + (PAR ? N : 0);

  typedef struct {
    int         kind;  // 0 = char_valid, 1 = framing_error, 2 = parity_error
    logic [7:0] data;
    int         cyc;
    logic       busy;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] char_w;
  logic       char_valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         rise_cyc = -1;
  logic       busy_prev = 1'b0;
  logic [7:0] last_good = 8'h00;
  ev_t        obs[$];
  ev_t        exp_q[$];

  uart_char_receiver #(.CLKS_PER_BIT(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .char         (char_w),
    .char_valid   (char_valid),
    .framing_error(framing_error),
    .parity_error (parity_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (char_valid)    obs.push_back('{0, char_w, cyc, busy});
    if (framing_error) obs.push_back('{1, char_w, cyc, busy});
    if (parity_error)  obs.push_back('{2, char_w, cyc, busy});
    if (busy && !busy_prev) rise_cyc = cyc;
    busy_prev = busy;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (N) @(posedge clock);
    #1;
  endtask

  // Drives one whole frame and queues the outcome the frame rules predict.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    int e;
    int kind;
    e = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR) drive_bit(par_b);
    drive_bit(stop_b);
    if (!stop_b) kind = 1;
    else if (PAR && (par_b != ^d)) kind = 2;
    else kind = 0;
    if (kind == 0) last_good = d;
    exp_q.push_back('{kind, last_good, e + LAT, 1'b0});
  endtask

  task automatic test_reset;
    rx = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({char_w, char_valid, framing_error, parity_error, busy} !== 12'h000) begin
      failures++;
      $display("FAIL reset_values got char=%h v=%b fe=%b pe=%b busy=%b exp all zero",
               char_w, char_valid, framing_error, parity_error, busy);
    end
    reset = 1'b1;
    idle(4);
  endtask

  task automatic test_single;
    int e;
    e = cyc + 1;
    rise_cyc = -1;
    send_frame(8'h4F, 1'b1, ^8'h4F);
    idle(2 * N);
    checks++;
    if (rise_cyc !== e + 2) begin
      failures++;
      $display("FAIL single_busy_rise got=%0d exp=%0d", rise_cyc, e + 2);
    end
    checks++;
    if (obs.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL single_count got=%0d exp=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data ||
          obs[i].cyc !== exp_q[i].cyc || obs[i].busy !== exp_q[i].busy) begin
        failures++;
        $display("FAIL single_event got kind=%0d data=%h cyc=%0d busy=%b exp kind=%0d data=%h cyc=%0d busy=0",
                 obs[i].kind, obs[i].data, obs[i].cyc, obs[i].busy,
                 exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] msg [10];
    msg = '{8'h4F, 8'h50, 8'h45, 8'h4E, 8'h57, 8'h49, 8'h4E, 8'h44, 8'h4F, 8'h57};
    for (int k = 0; k < 10; k++) send_frame(msg[k], 1'b1, ^msg[k]);
    idle(2 * N);
    checks++;
    if (obs.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data ||
          obs[i].cyc !== exp_q[i].cyc || obs[i].busy !== exp_q[i].busy) begin
        failures++;
        $display("FAIL b2b_event[%0d] got kind=%0d data=%h cyc=%0d exp kind=%0d data=%h cyc=%0d",
                 i, obs[i].kind, obs[i].data, obs[i].cyc,
                 exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_glitch;
    int waited;
    rx = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    rx = 1'b1;
    waited = 0;
    while (busy !== 1'b0 && waited < 9) begin
      @(posedge clock);
      #1;
      waited++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy got=%b exp=0 after %0d cycles", busy, waited);
    end
    idle(2 * N);
    checks++;
    if (obs.size() !== 0) begin
      failures++;
      $display("FAIL glitch_pulses got=%0d exp=0", obs.size());
    end
    obs.delete();
  endtask

  task automatic test_framing;
    send_frame(8'h41, 1'b0, ^8'h41);
    idle(2 * N);
    checks++;
    if (obs.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL framing_count got=%0d exp=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data ||
          obs[i].cyc !== exp_q[i].cyc) begin
        failures++;
        $display("FAIL framing_event got kind=%0d data=%h cyc=%0d exp kind=%0d data=%h cyc=%0d",
                 obs[i].kind, obs[i].data, obs[i].cyc,
                 exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    checks++;
    if (char_w !== last_good) begin
      failures++;
      $display("FAIL framing_char_hold got=%h exp=%h", char_w, last_good);
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'($urandom);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (N / 2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    last_good = 8'h00;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_busy got=%b exp=0", busy);
    end
    idle(3 * N);
    checks++;
    if (obs.size() !== 0 || char_w !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_abort got pulses=%0d char=%h exp pulses=0 char=00",
               obs.size(), char_w);
    end
    obs.delete();
    send_frame(8'h4E, 1'b1, ^8'h4E);
    idle(2 * N);
    checks++;
    if (obs.size() !== 1 || obs[0].kind !== 0 || obs[0].data !== 8'h4E ||
        obs[0].cyc !== exp_q[0].cyc) begin
      failures++;
      $display("FAIL reset_mid_recover got n=%0d exp n=1 kind=0 data=4E cyc=%0d",
               obs.size(), exp_q[0].cyc);
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic       stop_b;
    logic       par_b;
    for (int k = 0; k < 14; k++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      par_b  = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, stop_b, par_b);
      // A bad stop leaves the line low to its end; give a full idle bit after it.
      if (!stop_b) idle(N + $urandom_range(0, N));
      else idle($urandom_range(0, N));
    end
    idle(2 * N);
    checks++;
    if (obs.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL random_count got=%0d exp=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data ||
          obs[i].cyc !== exp_q[i].cyc || obs[i].busy !== exp_q[i].busy) begin
        failures++;
        $display("FAIL random_event[%0d] got kind=%0d data=%h cyc=%0d busy=%b exp kind=%0d data=%h cyc=%0d busy=0",
                 i, obs[i].kind, obs[i].data, obs[i].cyc, obs[i].busy,
                 exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    send_frame(8'h57, 1'b1, 1'b1);
    idle(N);
    send_frame(8'h57, 1'b1, 1'b0);
    idle(2 * N);
    checks++;
    if (obs.size() !== 2) begin
      failures++;
      $display("FAIL parity_count got=%0d exp=2", obs.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].kind !== exp_q[i].kind || obs[i].data !== exp_q[i].data ||
          obs[i].cyc !== exp_q[i].cyc) begin
        failures++;
        $display("FAIL parity_event[%0d] got kind=%0d data=%h cyc=%0d exp kind=%0d data=%h cyc=%0d",
                 i, obs[i].kind, obs[i].data, obs[i].cyc,
                 exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    rx = 1'b1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_random();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
